// File: rtl/rtable_grid.sv
// rtable_grid: programmable reward generator for the Q-learning grid world.
// Computes the reward for NUM_CH (cell, action) lookups per cycle. Off-grid
// moves get WALL_REWARD. Moves onto the goal cell get GOAL_REWARD. All other
// moves get the landing cell's entry in a run-time writable reward map.
// After reset or i_clear, an init sweep zeroes the map.
//
// Ports:
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_rd_valid/addr  per-channel lookup; addr = {row, col, act}
//   i_wr_en/cell/data  single reward-map write port
//   i_clear          restart the map-clearing sweep
//   o_ready          lookups and writes are accepted
//   o_rd_valid/data  per-channel result, two cycles after the request
module rtable_grid #(
   parameter int ROW_BITS    = 3,
   parameter int COL_BITS    = 3,
   parameter int NUM_CH      = 2,
   parameter int DATA_WIDTH  = 8,
   parameter int WALL_REWARD = -128,
   parameter int GOAL_REWARD = 127,
   parameter int GOAL_ROW    = (1 << ROW_BITS) - 1,
   parameter int GOAL_COL    = (1 << COL_BITS) - 1
) (
   input  logic                                        i_clk,
   input  logic                                        i_rst_n,
   input  logic [NUM_CH-1:0]                           i_rd_valid,
   input  logic [NUM_CH*(ROW_BITS+COL_BITS+2)-1:0]     i_rd_addr,
   input  logic                                        i_wr_en,
   input  logic [ROW_BITS+COL_BITS-1:0]                i_wr_cell,
   input  logic [DATA_WIDTH-1:0]                       i_wr_data,
   input  logic                                        i_clear,
   output logic                                        o_ready,
   output logic [NUM_CH-1:0]                           o_rd_valid,
   output logic [NUM_CH*DATA_WIDTH-1:0]                o_rd_data
);

   // state  | meaning
   // S_INIT | sweeping the map to zero, one entry per cycle; requests ignored
   // S_READY| lookups and writes accepted; i_clear restarts the sweep

   localparam int CELL_BITS  = ROW_BITS + COL_BITS;
   localparam int ADDR_WIDTH = CELL_BITS + 2;
   localparam int CELLS      = 1 << CELL_BITS;

   localparam logic [CELL_BITS-1:0]  GOAL_CELL = {ROW_BITS'(GOAL_ROW), COL_BITS'(GOAL_COL)};
   localparam logic [DATA_WIDTH-1:0] WALL_VAL  = DATA_WIDTH'(WALL_REWARD);
   localparam logic [DATA_WIDTH-1:0] GOAL_VAL  = DATA_WIDTH'(GOAL_REWARD);
   localparam logic [CELL_BITS-1:0]  CNT_LAST  = CELL_BITS'(CELLS - 1);

   typedef enum logic {S_INIT, S_READY} state_t;

   state_t               state_q, state_d;
   logic [CELL_BITS-1:0] cnt_q, cnt_d;
   logic                 ready_q, ready_d;

   logic [DATA_WIDTH-1:0] map_q [CELLS];
   logic [DATA_WIDTH-1:0] map_d [CELLS];

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_INIT: begin
            if (i_clear) begin
               cnt_d = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = S_READY;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_READY: begin
            if (i_clear) begin
               state_d = S_INIT;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = S_INIT;
            cnt_d   = '0;
         end
      endcase
      ready_d = (state_d == S_READY);
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= S_INIT;
         cnt_q   <= '0;
         ready_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ready_q <= ready_d;
      end
   end

   assign o_ready = ready_q;

   // The map has no reset. Its contents are only defined once the sweep has
   // visited every entry.
   always_comb begin
      map_d = map_q;
      if (state_q == S_INIT) begin
         map_d[cnt_q] = '0;
      end else if (i_wr_en) begin
         map_d[i_wr_cell] = i_wr_data;
      end
   end

   always_ff @(posedge i_clk) begin
      map_q <= map_d;
   end

   for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
      logic [ADDR_WIDTH-1:0] addr;
      logic [ROW_BITS-1:0]   row, nrow;
      logic [COL_BITS-1:0]   col, ncol;
      logic [1:0]            act;
      logic                  wall;

      logic                  s1_valid_q, s1_valid_d;
      logic                  s1_wall_q, s1_wall_d;
      logic                  s1_goal_q, s1_goal_d;
      logic [DATA_WIDTH-1:0] s1_map_q, s1_map_d;
      logic                  rd_valid_q, rd_valid_d;
      logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;

      assign addr = i_rd_addr[ch*ADDR_WIDTH +: ADDR_WIDTH];
      assign row  = addr[ADDR_WIDTH-1 -: ROW_BITS];
      assign col  = addr[2 +: COL_BITS];
      assign act  = addr[1:0];

      // Walls come from the edge position. The next cell may wrap, but a
      // wrapped cell is never used when the wall flag is set.
      always_comb begin
         nrow = row;
         ncol = col;
         wall = 1'b0;
         case (act)
            2'b00: begin wall = (col == '0); ncol = col - 1'b1; end
            2'b01: begin wall = (row == '0); nrow = row - 1'b1; end
            2'b10: begin wall = (col == '1); ncol = col + 1'b1; end
            default: begin wall = (row == '1); nrow = row + 1'b1; end
         endcase
      end

      always_comb begin
         s1_valid_d = ready_q & i_rd_valid[ch];
         s1_wall_d  = wall;
         s1_goal_d  = ({nrow, ncol} == GOAL_CELL);
         s1_map_d   = map_q[{nrow, ncol}];
         rd_valid_d = s1_valid_q;
         rd_data_d  = rd_data_q;
         if (s1_valid_q) begin
            if (s1_wall_q)      rd_data_d = WALL_VAL;
            else if (s1_goal_q) rd_data_d = GOAL_VAL;
            else                rd_data_d = s1_map_q;
         end
      end

      always_ff @(posedge i_clk or negedge i_rst_n) begin
         if (!i_rst_n) begin
            s1_valid_q <= 1'b0;
            s1_wall_q  <= 1'b0;
            s1_goal_q  <= 1'b0;
            s1_map_q   <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
         end else begin
            s1_valid_q <= s1_valid_d;
            s1_wall_q  <= s1_wall_d;
            s1_goal_q  <= s1_goal_d;
            s1_map_q   <= s1_map_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
         end
      end

      assign o_rd_valid[ch]                           = rd_valid_q;
      assign o_rd_data[ch*DATA_WIDTH +: DATA_WIDTH]   = rd_data_q;
   end

endmodule

// File: doc/rtable_grid.md
# rtable_grid

Parametrised, programmable reward generator for the Q-learning grid-world datapath. It replaces the fixed 8x8 reward ROM. It computes the reward for NUM_CH (state, action) lookups per cycle from three sources: grid dimensions, a goal cell, and a run-time writable per-cell reward map. Results feed the Q-update pipeline. Lookups are pipelined and valid-tagged. An internal FSM clears the reward map after reset or on request.

## Interface
- ROW_BITS, 3, row index width; grid has 2^ROW_BITS rows
- COL_BITS, 3, column index width; grid has 2^COL_BITS columns
- NUM_CH, 2, independent lookup channels
- DATA_WIDTH, 8, signed two's-complement reward width
- WALL_REWARD, -128, reward for any move off the grid
- GOAL_REWARD, 127, reward for a move landing on the goal cell
- GOAL_ROW, 2^ROW_BITS-1, goal row; GOAL_COL, 2^COL_BITS-1, goal column
- Derived: ADDR_WIDTH = ROW_BITS+COL_BITS+2, address is {row, col, act}; CELLS = 2^(ROW_BITS+COL_BITS)
- Clocking and reset (already decided): one clock; reset is asynchronous and active-low.
- i_clk  in  1  single clock, rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_rd_valid  in  NUM_CH  per-channel lookup request
- i_rd_addr  in  NUM_CH*ADDR_WIDTH  channel ch at bits [ch*ADDR_WIDTH +: ADDR_WIDTH]
- i_wr_en  in  1  write one reward-map entry
- i_wr_cell  in  ROW_BITS+COL_BITS  {row, col} of the entry
- i_wr_data  in  DATA_WIDTH  signed reward value for landing on that cell
- i_clear  in  1  single-cycle pulse; re-clears the whole map
- o_ready  out  1  high when lookups and writes are accepted
- o_rd_valid  out  NUM_CH  result valid per channel
- o_rd_data  out  NUM_CH*DATA_WIDTH  signed reward per channel, same packing as i_rd_addr

## Operation
- Action encoding: 00 left (col-1), 01 up (row-1), 10 right (col+1), 11 down (row+1).
- Reward priority per lookup:
  - Wall: next cell leaves the grid -> WALL_REWARD. Detected from the current row/col at 0 or at max, never by wrap-around.
  - Goal: else, next cell == (GOAL_ROW, GOAL_COL) -> GOAL_REWARD.
  - Map: else -> map entry of the next cell.
- A goal move has priority over a map entry written to the goal cell.
- Reward map: CELLS x DATA_WIDTH registers. One write port. NUM_CH read ports.
- FSM states:
  - INIT: o_ready=0. A counter sweeps the map, writing entry cnt=0 each cycle. At cnt==CELLS-1 it goes to READY and the counter returns to 0.
  - READY: o_ready=1. Lookups and writes are accepted. i_clear -> INIT with cnt=0.
- In INIT, i_rd_valid and i_wr_en are ignored. No o_rd_valid is generated for them, and no map write occurs.
- i_clear while in INIT restarts the sweep at 0.
- Lookups already in the pipeline when i_clear arrives still complete, using the map values sampled at their stage 1.
- A write and a lookup on the same cell in the same cycle: the lookup returns the old value (read-before-write). The new value is visible to lookups accepted from the next cycle.
- Channels are fully independent. All channels may hit the same cell in the same cycle.

## Timing
- Reset values: o_ready=0, o_rd_valid=0, o_rd_data=0, state=INIT, cnt=0. The map is undefined until the sweep completes.
- First o_ready=1 occurs CELLS cycles after the first rising edge with i_rst_n high (64 cycles at defaults).
- Lookup latency is 2 cycles. A request sampled at edge N gives o_rd_valid/o_rd_data at edge N+2.
  - Stage 1 registers the next cell, the wall/goal flags and the map read.
  - Stage 2 registers the selected reward.
- Throughput is one lookup per channel per cycle.
- o_rd_valid is a 1-cycle pulse per accepted request. o_rd_data holds its value while o_rd_valid is low.
- Asserting i_rst_n low at any time immediately zeroes all outputs and pipeline valids, and returns the FSM to INIT.
- The write-to-read visibility latency is 1 cycle.

## Test plan
- Defaults, after o_ready: ch0 addr {0,3,01} (up off the top row) -> o_rd_valid[0]=1 two cycles later, data -128. ch1 addr {0,0,00} is issued in the same cycle -> -128.
- Goal: {6,7,11} -> 127. {7,6,10} -> 127. {7,7,11} (off grid from the goal) -> -128, because wall wins.
- Map: write cell {2,2}=-10, then lookup {2,1,10} on the next cycle -> -10. Lookup {3,3,00} -> 0.
- Same-cycle write of {4,4}=25 with lookup {4,3,10} -> 0. The same lookup one cycle later -> 25.
- Reset and clear:
  - Release i_rst_n, drive lookups every cycle -> no o_rd_valid until o_ready rises at cycle 64.
  - Write {1,1}=5, pulse i_clear -> o_ready low for 64 cycles, then {1,0,10} -> 0.
- Async reset asserted mid-INIT and while 2 lookups are in flight -> o_rd_valid stays 0 and the sweep restarts at 0.
